// File: rtl/io_map_pkg.sv
// Address map and shared types for the CPU-side IO responder.
// LED_BLINK_EN enables the blink feature; the BLINK_ADDR constant is always defined here.
package io_map_pkg;

  localparam int IO_DATA_W = 16;

  localparam logic [31:0] LED_ADDR   = 32'hFFFF_FC60;
  localparam logic [31:0] BLINK_ADDR = 32'hFFFF_FC64;
  localparam logic [31:0] SW_ADDR    = 32'hFFFF_FC70;
  localparam logic [31:0] STAT_ADDR  = 32'hFFFF_FC74;

  typedef enum logic [2:0] {
    IO_NONE,
    IO_LED,
    IO_BLINK,
    IO_SW,
    IO_STAT
  } io_reg_e;

  // Full 32-bit compare; any partial match is treated as unmapped.
  function automatic io_reg_e io_decode(input logic [31:0] addr);
    case (addr)
      LED_ADDR:   return IO_LED;
      BLINK_ADDR: return IO_BLINK;
      SW_ADDR:    return IO_SW;
      STAT_ADDR:  return IO_STAT;
      default:    return IO_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU <-> peripheral IO bus: chip-select strobes, address, write data and read data.
// The CPU side drives strobes/address/data; the responder returns io_rdata combinationally.
interface io_responder_if;
  import io_map_pkg::*;

  logic                 LEDCtrl;
  logic                 SwitchCtrl;
  logic [31:0]          addr;
  logic [31:0]          write_data;
  logic [IO_DATA_W-1:0] io_rdata;

  modport master (
    output LEDCtrl, SwitchCtrl, addr, write_data,
    input  io_rdata
  );

  modport slave (
    input  LEDCtrl, SwitchCtrl, addr, write_data,
    output io_rdata
  );

endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a whole-vector debouncer for the board switches.
// changed_pulse is high during the cycle whose closing edge loads a new stable value.
module sw_debounce
  import io_map_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IO_DATA_W-1:0] raw,
  output logic [IO_DATA_W-1:0] stable,
  output logic                 changed_pulse
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [IO_DATA_W-1:0] s1;
  logic [IO_DATA_W-1:0] s2;
  logic [IO_DATA_W-1:0] sw_last;
  logic [IO_DATA_W-1:0] sw_stable;
  logic [CNT_W-1:0]     cnt;
  logic                 accept;

  // A candidate is accepted only after it has been seen unchanged for the full window.
  assign accept        = (s2 == sw_last) && (sw_last != sw_stable) && (cnt == CNT_LAST);
  assign changed_pulse = accept;
  assign stable        = sw_stable;

  // NOTE: non-blocking assignments so every flop samples pre-edge values; with
  // blocking ones s2 would take raw in the same edge and the synchronizer collapses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      sw_last   <= '0;
      sw_stable <= '0;
      cnt       <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != sw_last) begin
        sw_last <= s2;
        cnt     <= '0;
      end else if (sw_last != sw_stable) begin
        if (accept) begin
          sw_stable <= sw_last;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // Bounce settled back on the stable value: nothing to accept.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/io_responder.sv
// Peripheral endpoint of the CPU IO split: LED register, debounced switches, sticky change flag.
// Define LED_BLINK_EN to add the blink mask register and blink prescaler.
module io_responder
  import io_map_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned BLINK_HALF      = 25000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  io_responder_if.slave        bus,
  input  logic [IO_DATA_W-1:0] sw_in,
  output logic [IO_DATA_W-1:0] led_out
);

  io_reg_e              sel;
  logic                 wr_led;
  logic                 rd_stat;
  logic [IO_DATA_W-1:0] led_reg;
  logic [IO_DATA_W-1:0] sw_stable;
  logic                 sw_changed;
  logic                 chg;
  logic [IO_DATA_W-1:0] blink_rdata;
  logic                 unused_wdata_hi;

  assign sel             = io_decode(bus.addr);
  assign wr_led          = bus.LEDCtrl && (sel == IO_LED);
  assign rd_stat         = bus.SwitchCtrl && (sel == IO_STAT);
  assign unused_wdata_hi = ^bus.write_data[31:IO_DATA_W];

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw          (sw_in),
    .stable       (sw_stable),
    .changed_pulse(sw_changed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg <= '0;
    end else if (wr_led) begin
      led_reg <= bus.write_data[IO_DATA_W-1:0];
    end
  end

  // Set has priority so an acceptance coinciding with a status read is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg <= 1'b0;
    end else if (sw_changed) begin
      chg <= 1'b1;
    end else if (rd_stat) begin
      chg <= 1'b0;
    end
  end

`ifdef LED_BLINK_EN
  localparam int unsigned     PRE_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_HALF - 1);

  logic [IO_DATA_W-1:0] blink_mask;
  logic [PRE_W-1:0]     pre_cnt;
  logic                 phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_mask <= '0;
      pre_cnt    <= '0;
      phase      <= 1'b0;
    end else begin
      if (bus.LEDCtrl && (sel == IO_BLINK)) begin
        blink_mask <= bus.write_data[IO_DATA_W-1:0];
      end
      // Free-running: phase flips once every BLINK_HALF cycles.
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
        phase   <= ~phase;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  assign blink_rdata = blink_mask;
  assign led_out     = led_reg & ~(blink_mask & {IO_DATA_W{phase}});
`else
  assign blink_rdata = '0;
  assign led_out     = led_reg;
`endif

  // NOTE: the default is assigned first so every path drives io_rdata and no latch is inferred.
  always_comb begin
    bus.io_rdata = '0;
    if (bus.SwitchCtrl) begin
      case (sel)
        IO_SW:    bus.io_rdata = sw_stable;
        IO_STAT:  bus.io_rdata = {{(IO_DATA_W-1){1'b0}}, chg};
        IO_LED:   bus.io_rdata = led_reg;
        IO_BLINK: bus.io_rdata = blink_rdata;
        default:  bus.io_rdata = '0;
      endcase
    end
  end

endmodule
